spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
- Command/transaction sequencer between the SPI slave byte interface and the shared video memory/register port of the Arduino-driven VGA GPU.
- Parses framed SPI byte streams into write, read and status commands.
- Issues request/grant accesses to the memory arbiter, where video fetch has priority.
- Preloads read data into the SPI transmit byte so the host sees it on the following byte.

Parameters:
- ADDR_W, 8, memory address width; address counter wraps modulo 2^ADDR_W.
- DATA_W, 8, data byte width; fixed to the SPI byte, must be 8.

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain)
- rst  input  1  asynchronous active-high reset
- ss_active  input  1  high while SPI slave select is asserted; already synchronized to clk
- rx_valid  input  1  one-cycle pulse: a full byte has been received
- rx_byte  input  8  received byte; valid with rx_valid
- tx_load  output  1  one-cycle pulse: load tx_byte into the SPI shift register
- tx_byte  output  8  byte to shift out on MISO next
- mem_req  output  1  memory access request
- mem_we  output  1  1 = write, 0 = read; stable while mem_req
- mem_addr  output  ADDR_W  access address; stable while mem_req
- mem_wdata  output  8  write data; stable while mem_req
- mem_gnt  input  1  arbiter grant; access completes in any cycle where mem_req & mem_gnt
- mem_rvalid  input  1  read data valid; arrives ≥1 cycle after the read grant
- mem_rdata  input  8  read data
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky OR of status bits [1:0]

Behaviour:
- Reset values: all outputs 0; state IDLE; addr counter 0; status bits 0; tx_byte 0x00.
- Opcode (first byte after ss_active rises):
  - 0x00 NOP.
  - 0x01 WRITE.
  - 0x02 READ.
  - 0x03 STATUS.
  - Any other value: set bad_op (status[0]) and go to DISCARD.
- FSM states: IDLE, OPC, ADDR, WDATA, WREQ, RREQ, RWAIT, DISCARD.
- IDLE -> OPC when ss_active=1.
- OPC on rx_valid:
  - WRITE/READ -> ADDR.
  - NOP -> DISCARD.
  - STATUS: tx_byte <= {6'b0, overrun, bad_op}, tx_load pulse, status bits cleared in the same cycle, -> DISCARD.
- ADDR on rx_valid: addr <= rx_byte[ADDR_W-1:0].
  - WRITE -> WDATA.
  - READ -> RREQ, issuing a prefetch of addr.
- WDATA on rx_valid: latch mem_wdata, assert mem_req, mem_we=1, -> WREQ.
- WREQ: hold req until the cycle where mem_gnt=1. Next cycle: mem_req=0, addr++, -> WDATA. Burst continues until ss_active falls.
- RREQ: mem_req=1, mem_we=0 until granted, then -> RWAIT.
- RWAIT on mem_rvalid: tx_byte <= mem_rdata, tx_load pulse, addr++, -> RDWAIT-byte.
  - The host's next byte clocks out this data; that byte's rx_valid (dummy) triggers the next RREQ.
  - Implemented as a WDATA-like wait in the read path, reusing the WDATA state with a read flag.
- Minimum latency:
  - Write: rx_valid to mem_req is 1 cycle.
  - Read: rx_valid (addr) to mem_req is 1 cycle; tx_load is 1 cycle after mem_rvalid.
- Overrun: rx_valid while in WREQ, RREQ or RWAIT sets overrun (status[1]). The byte is dropped and the outstanding access completes normally.
- Address counter wraps 2^ADDR_W-1 -> 0 silently.
- ss_active falling, in any state: next cycle -> IDLE.
  - An ungranted mem_req is dropped.
  - A grant in the same cycle as the fall still completes the access.
  - Pending rvalid is ignored; no tx_load.
  - Status bits are retained.
- rx_valid coincident with the ss_active fall: ignored.
- ss_active rise while not in IDLE is impossible by construction; treat it as a new transaction only after IDLE.
- rst mid-transaction: immediate return to reset values; mem_req drops asynchronously.

Test Plan:
- WRITE: ss, bytes 0x01,0x10,0xAA,0xBB, mem_gnt tied 1 -> writes (0x10,0xAA) then (0x11,0xBB); mem_req high exactly 1 cycle each.
- READ: memory holds 0x10=0x5C, 0x11=0xC3; ss, bytes 0x02,0x10,dummy,dummy -> tx_byte 0x5C loaded before byte 3, then 0xC3; addr ends at 0x12.
- Grant stall: WRITE with mem_gnt low for 7 cycles -> mem_req, mem_addr, mem_wdata stable for 8 cycles; a second rx_valid during the stall sets overrun; a STATUS command then returns 0x02 and clears err.
- Wrap and bad opcode: WRITE at addr 0xFF with 2 data bytes -> addresses 0xFF then 0x00. Separate transaction with opcode 0x7E -> err=1, no mem_req, STATUS returns 0x01.
- Abort: drop ss_active during RREQ with gnt low -> mem_req falls next cycle, IDLE, no tx_load, busy=0.
- Reset mid-burst: assert rst during WREQ -> all outputs 0 asynchronously; after release, a fresh WRITE works from OPC.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: turns framed SPI byte streams into write/read/status accesses
// on the shared memory port, and preloads read data into the SPI transmit byte.
module spi_cmd_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss_active,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_byte,
   output logic              tx_load,
   output logic [DATA_W-1:0] tx_byte,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] OPC     = 3'd1;
   localparam logic [2:0] ADDR    = 3'd2;
   localparam logic [2:0] WDATA   = 3'd3;
   localparam logic [2:0] WREQ    = 3'd4;
   localparam logic [2:0] RREQ    = 3'd5;
   localparam logic [2:0] RWAIT   = 3'd6;
   localparam logic [2:0] DISCARD = 3'd7;

   logic [2:0]        state;
   logic              rd;
   logic              bad_op;
   logic              overrun;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;

   // request is decoded from state so reset removes it without waiting for a clock
   assign mem_req   = state == WREQ || state == RREQ;
   assign mem_we    = state == WREQ;
   assign mem_addr  = addr;
   assign mem_wdata = wdata;
   assign busy      = state != IDLE;
   assign err       = bad_op | overrun;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd      <= 1'b0;
         bad_op  <= 1'b0;
         overrun <= 1'b0;
         addr    <= '0;
         wdata   <= '0;
         tx_byte <= '0;
         tx_load <= 1'b0;
      end else begin
         tx_load <= 1'b0;
         if (state != IDLE && !ss_active)
            state <= IDLE;
         else
            case (state)
               IDLE: if (ss_active) state <= OPC;
               OPC: if (rx_valid) begin
                  if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                     rd    <= rx_byte[1];
                     state <= ADDR;
                  end else if (rx_byte == 8'h03) begin
                     tx_byte <= {{(DATA_W-2){1'b0}}, overrun, bad_op};
                     tx_load <= 1'b1;
                     bad_op  <= 1'b0;
                     overrun <= 1'b0;
                     state   <= DISCARD;
                  end else begin
                     bad_op <= bad_op | (rx_byte != 8'h00);
                     state  <= DISCARD;
                  end
               end
               ADDR: if (rx_valid) begin
                  addr  <= rx_byte[ADDR_W-1:0];
                  state <= rd ? RREQ : WDATA;
               end
               // in the read path this waits for the dummy byte that shifts out the preloaded data
               WDATA: if (rx_valid) begin
                  wdata <= rd ? wdata : rx_byte;
                  state <= rd ? RREQ : WREQ;
               end
               WREQ: begin
                  overrun <= overrun | rx_valid;
                  if (mem_gnt) begin
                     addr  <= addr + 1'b1;
                     state <= WDATA;
                  end
               end
               RREQ: begin
                  overrun <= overrun | rx_valid;
                  if (mem_gnt) state <= RWAIT;
               end
               RWAIT: begin
                  overrun <= overrun | rx_valid;
                  if (mem_rvalid) begin
                     tx_byte <= mem_rdata;
                     tx_load <= 1'b1;
                     addr    <= addr + 1'b1;
                     state   <= WDATA;
                  end
               end
               default: ;
            endcase
      end
   end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed stimulus with expected-result queues checked
// against writes, reads and tx loads recorded by a memory/arbiter model.
module tb_spi_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       ss_active;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_load;
   logic [7:0] tx_byte;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_gnt;
   logic       mem_rvalid = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [256];
   logic [15:0] obs_wr [64];
   logic [7:0]  obs_rd [64];
   logic [7:0]  obs_tx [64];
   int n_wr = 0, n_rd = 0, n_tx = 0, req_cycles = 0;
   int rd_cnt = 0;
   logic [7:0] rd_addr = 8'h00;

   logic [15:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   logic [7:0]  exp_tx [$];
   int c_wr = 0, c_rd = 0, c_tx = 0;

   spi_cmd_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .ss_active(ss_active), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_load(tx_load), .tx_byte(tx_byte), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // memory/arbiter model: read data returns one cycle after the grant
   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      if (rd_cnt != 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[rd_addr];
         end
      end
      if (mem_req) req_cycles++;
      if (tx_load) begin
         obs_tx[n_tx % 64] = tx_byte;
         n_tx++;
      end
      if (mem_req && mem_gnt) begin
         if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            obs_wr[n_wr % 64] = {mem_addr, mem_wdata};
            n_wr++;
         end else begin
            obs_rd[n_rd % 64] = mem_addr;
            n_rd++;
            rd_addr = mem_addr;
            rd_cnt  = 1;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick;
      rx_valid = 1'b0;
      repeat (gap) tick;
   endtask

   task automatic ss_start;
      ss_active = 1'b1;
      tick;
   endtask

   task automatic ss_end;
      ss_active = 1'b0;
      tick;
      tick;
   endtask

   task automatic drain;
      while (exp_wr.size() != 0 && c_wr < n_wr) begin
         chk("wr", obs_wr[c_wr % 64], exp_wr.pop_front());
         c_wr++;
      end
      while (exp_rd.size() != 0 && c_rd < n_rd) begin
         chk("rd_addr", {8'h00, obs_rd[c_rd % 64]}, {8'h00, exp_rd.pop_front()});
         c_rd++;
      end
      while (exp_tx.size() != 0 && c_tx < n_tx) begin
         chk("tx", {8'h00, obs_tx[c_tx % 64]}, {8'h00, exp_tx.pop_front()});
         c_tx++;
      end
      chk("wr_missing", 16'(exp_wr.size()), 16'd0);
      chk("wr_extra", 16'(n_wr - c_wr), 16'd0);
      chk("rd_missing", 16'(exp_rd.size()), 16'd0);
      chk("rd_extra", 16'(n_rd - c_rd), 16'd0);
      chk("tx_missing", 16'(exp_tx.size()), 16'd0);
      chk("tx_extra", 16'(n_tx - c_tx), 16'd0);
      exp_wr.delete();
      exp_rd.delete();
      exp_tx.delete();
      c_wr = n_wr;
      c_rd = n_rd;
      c_tx = n_tx;
   endtask

   initial begin
      int r0;
      int t0;
      rst = 1'b1;
      ss_active = 1'b0;
      rx_valid = 1'b0;
      rx_byte = 8'h00;
      mem_gnt = 1'b0;
      repeat (2) tick;
      chk("rst_outs", {tx_load, mem_req, mem_we, busy, err, 11'd0}, 16'd0);
      chk("rst_addr_wdata", {mem_addr, mem_wdata}, 16'h0000);
      chk("rst_tx", {8'h00, tx_byte}, 16'h0000);
      rst = 1'b0;
      tick;

      // write burst with grant tied high
      mem_gnt = 1'b1;
      exp_wr.push_back(16'h10AA);
      exp_wr.push_back(16'h11BB);
      ss_start;
      chk("busy_opc", {15'd0, busy}, 16'd1);
      send(8'h01, 2);
      send(8'h10, 2);
      r0 = req_cycles;
      send(8'hAA, 3);
      chk("wr1_req_len", 16'(req_cycles - r0), 16'd1);
      r0 = req_cycles;
      send(8'hBB, 3);
      chk("wr2_req_len", 16'(req_cycles - r0), 16'd1);
      chk("wr_addr_end", {8'h00, mem_addr}, 16'h0012);
      ss_end;
      chk("idle_after_wr", {15'd0, busy}, 16'd0);
      drain;

      // preload memory for the read test
      exp_wr.push_back(16'h105C);
      exp_wr.push_back(16'h11C3);
      ss_start;
      send(8'h01, 2);
      send(8'h10, 2);
      send(8'h5C, 3);
      send(8'hC3, 3);
      ss_end;
      drain;

      // read burst; the final dummy byte's prefetch is cut off by ss falling
      exp_rd.push_back(8'h10);
      exp_rd.push_back(8'h11);
      exp_rd.push_back(8'h12);
      exp_tx.push_back(8'h5C);
      exp_tx.push_back(8'hC3);
      ss_start;
      send(8'h02, 2);
      send(8'h10, 5);
      chk("rd_pre_byte3", {8'h00, tx_byte}, 16'h005C);
      send(8'h00, 5);
      chk("rd_pre_byte4", {8'h00, tx_byte}, 16'h00C3);
      send(8'h00, 0);
      ss_end;
      chk("rd_addr_end", {8'h00, mem_addr}, 16'h0012);
      chk("rd_idle", {15'd0, busy}, 16'd0);
      drain;

      // grant stall with an overrun byte, then status readback
      mem_gnt = 1'b0;
      exp_wr.push_back(16'h2077);
      ss_start;
      send(8'h01, 2);
      send(8'h20, 2);
      r0 = req_cycles;
      send(8'h77, 0);
      for (int i = 0; i < 7; i++) begin
         rx_byte  = 8'h99;
         rx_valid = (i == 3);
         tick;
         chk("stall_hold", {mem_req, mem_we, 6'd0, mem_addr}, {2'b11, 6'd0, 8'h20});
         chk("stall_wdata", {8'h00, mem_wdata}, 16'h0077);
      end
      rx_valid = 1'b0;
      mem_gnt = 1'b1;
      tick;
      tick;
      chk("stall_req_len", 16'(req_cycles - r0), 16'd8);
      chk("stall_err", {15'd0, err}, 16'd1);
      ss_end;
      drain;
      exp_tx.push_back(8'h02);
      ss_start;
      send(8'h03, 3);
      chk("status_clr_err", {15'd0, err}, 16'd0);
      ss_end;
      drain;

      // address wrap, then a bad opcode
      exp_wr.push_back(16'hFF11);
      exp_wr.push_back(16'h0022);
      ss_start;
      send(8'h01, 2);
      send(8'hFF, 2);
      send(8'h11, 3);
      send(8'h22, 3);
      chk("wrap_addr", {8'h00, mem_addr}, 16'h0001);
      ss_end;
      drain;
      r0 = req_cycles;
      ss_start;
      send(8'h7E, 3);
      chk("badop_err", {15'd0, err}, 16'd1);
      ss_end;
      chk("badop_no_req", 16'(req_cycles - r0), 16'd0);
      drain;
      exp_tx.push_back(8'h01);
      ss_start;
      send(8'h03, 3);
      chk("status2_clr", {15'd0, err}, 16'd0);
      ss_end;
      drain;

      // abort during an ungranted read request
      mem_gnt = 1'b0;
      t0 = n_tx;
      ss_start;
      send(8'h02, 2);
      send(8'h40, 0);
      chk("abort_req_hi", {15'd0, mem_req}, 16'd1);
      ss_active = 1'b0;
      tick;
      chk("abort_req_lo", {mem_req, busy, 14'd0}, 16'd0);
      repeat (3) tick;
      chk("abort_no_tx", 16'(n_tx - t0), 16'd0);
      drain;

      // asynchronous reset while a write waits for grant
      ss_start;
      send(8'h01, 2);
      send(8'h50, 2);
      send(8'h66, 0);
      chk("rst_mid_req", {15'd0, mem_req}, 16'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_outs", {tx_load, mem_req, mem_we, busy, err, 11'd0}, 16'd0);
      chk("rst_mid_bus", {mem_addr, mem_wdata}, 16'h0000);
      chk("rst_mid_tx", {8'h00, tx_byte}, 16'h0000);
      ss_active = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      mem_gnt = 1'b1;
      exp_wr.push_back(16'h605A);
      ss_start;
      send(8'h01, 2);
      send(8'h60, 2);
      send(8'h5A, 3);
      chk("post_rst_addr", {8'h00, mem_addr}, 16'h0061);
      ss_end;
      drain;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
